// File: rtl/aes_pkg.sv
// Shared AES types and constants for the iterative round controller.
package aes_pkg;

  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    AES128  = 2'd0,
    AES192  = 2'd1,
    AES256  = 2'd2,
    AES_ILL = 2'd3
  } aes_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    KEY0,
    RUN,
    DONE
  } ctrl_state_t;

  // An illegal mode is processed as AES-128.
  function automatic logic [3:0] aes_nr(input aes_mode_t mode);
    case (mode)
      AES192:  return 4'd12;
      AES256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block-in / round-key / ciphertext-out signal bundle of aes_round_ctrl.
interface aes_round_ctrl_if #(
  parameter int RK_AW = 4
) ();
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_mode;
  logic [AES_BLK_W-1:0] in_data;
  logic                 rk_rd_en;
  logic [RK_AW-1:0]     rk_addr;
  logic [AES_BLK_W-1:0] rk_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [AES_BLK_W-1:0] out_data;
  logic                 out_err;

  modport slave (
    input  in_valid, in_mode, in_data, rk_data, out_ready,
    output in_ready, rk_rd_en, rk_addr, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_mode, in_data, rk_data, out_ready,
    input  in_ready, rk_rd_en, rk_addr, out_valid, out_data, out_err
  );
endinterface

// File: rtl/aes_rounddata.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped on the final round) and AddRoundKey.
module aes_rounddata
  import aes_pkg::*;
(
  input  logic [3:0]           round_i,
  input  aes_mode_t            mode_i,
  input  logic [AES_BLK_W-1:0] round_key_i,
  input  logic [AES_BLK_W-1:0] data_i,
  output logic [AES_BLK_W-1:0] data_o
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // Inverse as x^254 built from successive squares, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] b;
    sq = x;
    b  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      b  = gf_mul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  logic       final_rnd;

  assign final_rnd = (round_i == aes_nr(mode_i));

  // Byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    assign sb[gi] = sbox(data_i[AES_BLK_W-1-8*gi -: 8]);
    assign sr[gi] = sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
    assign data_o[AES_BLK_W-1-8*gi -: 8] =
        (final_rnd ? sr[gi] : mc[gi]) ^ round_key_i[AES_BLK_W-1-8*gi -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*gi+0];
    assign a1 = sr[4*gi+1];
    assign a2 = sr[4*gi+2];
    assign a3 = sr[4*gi+3];
    assign mc[4*gi+0] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*gi+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mc[4*gi+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mc[4*gi+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer, one round per clock over an external
// 1-cycle-latency round-key store. Optional macro: AES_CTRL_PERF_CNT_EN (blk_count).
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int DATA_W = AES_BLK_W,
  parameter int RK_AW  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  aes_round_ctrl_if.slave   ctrl_if
`ifdef AES_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]       blk_count
`endif
);

  ctrl_state_t       fsm_q;
  aes_mode_t         mode_q;
  logic [DATA_W-1:0] pt_q;
  logic [DATA_W-1:0] state_q;
  logic [DATA_W-1:0] state_d;
  logic [3:0]        round_q;
  logic [3:0]        nr;
  logic [RK_AW-1:0]  rk_addr_q;
  logic              rk_rd_en_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              err_q;

  assign nr = aes_nr(mode_q);

  aes_rounddata u_rounddata (
    .round_i     (round_q),
    .mode_i      (mode_q),
    .round_key_i (ctrl_if.rk_data),
    .data_i      (state_q),
    .data_o      (state_d)
  );

  assign ctrl_if.in_ready  = in_ready_q;
  assign ctrl_if.rk_rd_en  = rk_rd_en_q;
  assign ctrl_if.rk_addr   = rk_addr_q;
  assign ctrl_if.out_valid = out_valid_q;
  assign ctrl_if.out_data  = state_q;
  assign ctrl_if.out_err   = err_q;

  // The key for the current round is always requested one cycle ahead, so
  // KEY0 spends its first cycle waiting for round key 0 to come back.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q       <= IDLE;
      mode_q      <= AES128;
      pt_q        <= '0;
      state_q     <= '0;
      round_q     <= '0;
      rk_addr_q   <= '0;
      rk_rd_en_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (ctrl_if.in_valid) begin
            pt_q       <= ctrl_if.in_data;
            mode_q     <= aes_mode_t'(ctrl_if.in_mode);
            err_q      <= (ctrl_if.in_mode == 2'd3);
            rk_rd_en_q <= 1'b1;
            rk_addr_q  <= '0;
            round_q    <= '0;
            in_ready_q <= 1'b0;
            fsm_q      <= KEY0;
          end
        end
        KEY0: begin
          if (rk_addr_q == '0) begin
            rk_addr_q <= RK_AW'(1);
          end else begin
            state_q   <= pt_q ^ ctrl_if.rk_data;
            round_q   <= 4'd1;
            rk_addr_q <= RK_AW'(2);
            fsm_q     <= RUN;
          end
        end
        RUN: begin
          state_q <= state_d;
          if (round_q == nr) begin
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
            if (round_q + 4'd1 < nr) begin
              rk_addr_q <= RK_AW'(round_q + 4'd2);
            end else begin
              rk_rd_en_q <= 1'b0;
            end
          end
        end
        DONE: begin
          if (ctrl_if.out_ready) begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            round_q     <= '0;
            fsm_q       <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

`ifdef AES_CTRL_PERF_CNT_EN
  logic [31:0] blk_count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blk_count_q <= '0;
    end else if (out_valid_q && ctrl_if.out_ready) begin
      blk_count_q <= blk_count_q + 32'd1;
    end
  end

  assign blk_count = blk_count_q;
`endif

endmodule
